// File: rtl/oversample_voter.sv
// oversample_voter
//   Majority voter for an oversampled serial line. Around the middle of each
//   bit period (edge_cnt == prescale/2) it captures NSAMP consecutive samples
//   of rx_in, then publishes the majority value with a one-cycle bit_valid
//   pulse. noise_err flags a decision whose samples were not unanimous.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   samp_en     sampling enable; low clears everything at the next edge
//   prescale    edges per bit (oversampling ratio)
//   edge_cnt    current edge index within the bit, 0..prescale-1
//   rx_in       synchronised serial input
//   sampled_bit majority-voted bit (held between decisions)
//   bit_valid   one-cycle pulse when sampled_bit is updated
//   noise_err   non-unanimous samples in the last decision
//   cfg_err     prescale is too small to hold the sample window
//   state_dbg   current FSM state, for observation only
//
// Handshake: there is no back-pressure. bit_valid is a single-cycle strobe;
// sampled_bit and noise_err are meaningful in the cycle bit_valid is high and
// simply hold their value afterwards.
module oversample_voter #(
  parameter int PRESCALE_W = 6,
  parameter int NSAMP      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  samp_en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic                  rx_in,
  output logic                  sampled_bit,
  output logic                  bit_valid,
  output logic                  noise_err,
  output logic                  cfg_err,
  output logic [1:0]            state_dbg
);

  localparam int KW = $clog2(NSAMP + 1);
  localparam int H  = (NSAMP - 1) / 2;
  // One spare bit so MID+H cannot wrap when compared against prescale.
  localparam int W1 = PRESCALE_W + 1;

  localparam logic [W1-1:0] H_P = W1'(H);
  localparam logic [KW-1:0] H_K = KW'(H);
  localparam logic [KW-1:0] N_K = KW'(NSAMP);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DECIDE  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [KW-1:0] k, k_n;
  logic [KW-1:0] ones, ones_n;
  logic          sampled_n, valid_n, noise_n, cfg_n;

  logic [W1-1:0] ps_x, ec_x, mid, win_start, win_cur;
  logic          cfg_cond;

  assign ps_x      = {1'b0, prescale};
  assign ec_x      = {1'b0, edge_cnt};
  assign mid       = ps_x >> 1;
  assign cfg_cond  = (mid < H_P) || ((mid + H_P) >= ps_x);
  // Only meaningful when cfg_cond is false (then mid >= H).
  assign win_start = mid - H_P;
  assign win_cur   = win_start + W1'(k);
  assign state_dbg = state;

  always_comb begin
    state_n   = state;
    k_n       = k;
    ones_n    = ones;
    sampled_n = sampled_bit;
    noise_n   = noise_err;
    valid_n   = 1'b0;
    cfg_n     = cfg_cond;

    if (!samp_en) begin
      state_n   = IDLE;
      k_n       = '0;
      ones_n    = '0;
      sampled_n = 1'b0;
      noise_n   = 1'b0;
      cfg_n     = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!cfg_cond && (ec_x == win_start)) begin
            ones_n  = KW'(rx_in);
            k_n     = KW'(1);
            state_n = (NSAMP == 1) ? DECIDE : COLLECT;
          end
        end
        COLLECT: begin
          if (cfg_cond) begin
            // prescale changed under us: the window no longer fits.
            state_n = IDLE;
            k_n     = '0;
            ones_n  = '0;
          end else if (ec_x == win_cur) begin
            ones_n = ones + KW'(rx_in);
            k_n    = k + KW'(1);
            if ((k + KW'(1)) == N_K) state_n = DECIDE;
          end else if ((ec_x == '0) || (ec_x > win_cur)) begin
            // Bit period wrapped or an edge was skipped: partial set is void.
            state_n = IDLE;
            k_n     = '0;
            ones_n  = '0;
          end
        end
        DECIDE: begin
          sampled_n = (ones > H_K);
          noise_n   = (ones != '0) && (ones != N_K);
          valid_n   = 1'b1;
          state_n   = IDLE;
          k_n       = '0;
          ones_n    = '0;
        end
        default: begin
          state_n = IDLE;
          k_n     = '0;
          ones_n  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      k           <= '0;
      ones        <= '0;
      sampled_bit <= 1'b0;
      bit_valid   <= 1'b0;
      noise_err   <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state       <= state_n;
      k           <= k_n;
      ones        <= ones_n;
      sampled_bit <= sampled_n;
      bit_valid   <= valid_n;
      noise_err   <= noise_n;
      cfg_err     <= cfg_n;
    end
  end

endmodule

// File: tb/tb_oversample_voter.sv
// tb_oversample_voter
//   Two instances (NSAMP=3 and NSAMP=5) share clock and reset; each has its
//   own stimulus. Directed windows use expected values taken straight from
//   the voting rules; the random test predicts each decision from the raw
//   samples by counting ones in the window around prescale/2.
module tb_oversample_voter;

  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst;

  logic          en3, rx3, sb3, bv3, ne3, ce3;
  logic [PW-1:0] ps3, ec3;
  logic [1:0]    st3;
  logic          en5, rx5, sb5, bv5, ne5, ce5;
  logic [PW-1:0] ps5, ec5;
  logic [1:0]    st5;

  int vectors     = 0;
  int miscompares = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  oversample_voter #(.PRESCALE_W(PW), .NSAMP(3)) dut3 (
    .clk(clk), .rst(rst), .samp_en(en3), .prescale(ps3), .edge_cnt(ec3),
    .rx_in(rx3), .sampled_bit(sb3), .bit_valid(bv3), .noise_err(ne3),
    .cfg_err(ce3), .state_dbg(st3)
  );

  oversample_voter #(.PRESCALE_W(PW), .NSAMP(5)) dut5 (
    .clk(clk), .rst(rst), .samp_en(en5), .prescale(ps5), .edge_cnt(ec5),
    .rx_in(rx5), .sampled_bit(sb5), .bit_valid(bv5), .noise_err(ne5),
    .cfg_err(ce5), .state_dbg(st5)
  );

  // Driver: present inputs to one instance, then advance one clock and
  // settle 1 time unit past the edge before anything is sampled.
  task automatic apply(input int d, input logic en, input int ec, input logic rx);
    if (d == 3) begin
      en3 = en; ec3 = PW'(ec); rx3 = rx;
    end else begin
      en5 = en; ec5 = PW'(ec); rx5 = rx;
    end
    @(posedge clk); #1;
  endtask

  task automatic obs(input int d, output logic sb, output logic bv,
                     output logic ne, output logic ce);
    if (d == 3) begin
      sb = sb3; bv = bv3; ne = ne3; ce = ce3;
    end else begin
      sb = sb5; bv = bv5; ne = ne5; ce = ce5;
    end
  endtask

  task automatic test_reset();
    logic sb, bv, ne, ce;
    rst = 1'b1;
    en3 = 1'b0; ps3 = PW'(8);  ec3 = '0; rx3 = 1'b0;
    en5 = 1'b0; ps5 = PW'(16); ec5 = '0; rx5 = 1'b0;
    #2;
    for (int i = 0; i < 2; i++) begin
      obs((i == 0) ? 3 : 5, sb, bv, ne, ce);
      vectors++;
      if ({sb, bv, ne, ce} !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_outputs dut%0d: got %b expected 0000", (i == 0) ? 3 : 5, {sb, bv, ne, ce});
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One full bit period; pat[i] is the i-th sample of the window.
  task automatic test_window(input int d, input int p, input int n, input logic [6:0] pat,
                             input logic exp_bit, input logic exp_noise, input string name);
    logic sb, bv, ne, ce, rx;
    int ws, we;
    ws = p / 2 - (n - 1) / 2;
    we = ws + n - 1;
    if (d == 3) ps3 = PW'(p); else ps5 = PW'(p);
    for (int e = 0; e < p; e++) begin
      rx = (e >= ws && e <= we) ? pat[e - ws] : 1'($urandom_range(0, 1));
      apply(d, 1'b1, e, rx);
      obs(d, sb, bv, ne, ce);
      vectors++;
      if (bv !== (e == we + 1)) begin
        miscompares++;
        $display("FAIL %s bit_valid at edge %0d: got %b expected %b", name, e, bv, (e == we + 1));
      end
      if (e > we) begin
        vectors++;
        if ({sb, ne} !== {exp_bit, exp_noise}) begin
          miscompares++;
          $display("FAIL %s bit/noise at edge %0d: got %b%b expected %b%b", name, e, sb, ne, exp_bit, exp_noise);
        end
      end
    end
  endtask

  task automatic test_votes();
    test_window(3, 8,  3, 7'b0000111, 1'b1, 1'b0, "unanimous_one");
    test_window(3, 8,  3, 7'b0000101, 1'b1, 1'b1, "noisy_101");
    test_window(3, 8,  3, 7'b0000100, 1'b0, 1'b1, "noisy_001");
    test_window(3, 8,  3, 7'b0000000, 1'b0, 1'b0, "unanimous_zero");
    test_window(5, 16, 5, 7'b0010110, 1'b1, 1'b1, "n5_01101");
    test_window(5, 16, 5, 7'b0011111, 1'b1, 1'b0, "n5_all_one");
    test_window(5, 16, 5, 7'b0000011, 1'b0, 1'b1, "n5_two_of_five");
  endtask

  task automatic test_cfg_err();
    logic sb, bv, ne, ce;
    int   ptab[4] = '{1, 2, 3, 4};
    logic etab[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    // NSAMP=5, prescale=4: window cannot fit, nothing may be decided.
    ps5 = PW'(4);
    for (int r = 0; r < 3; r++) begin
      for (int e = 0; e < 4; e++) begin
        apply(5, 1'b1, e, 1'($urandom_range(0, 1)));
        obs(5, sb, bv, ne, ce);
        vectors++;
        if ({ce, bv} !== 2'b10) begin
          miscompares++;
          $display("FAIL cfg_err_n5_p4 edge %0d: got cfg/valid %b%b expected 10", e, ce, bv);
        end
      end
    end
    apply(5, 1'b0, 0, 1'b0);
    vectors++;
    if (ce5 !== 1'b0) begin
      miscompares++;
      $display("FAIL cfg_err_cleared_by_disable: got %b expected 0", ce5);
    end
    // Boundary prescale values for NSAMP=3.
    for (int i = 0; i < 4; i++) begin
      ps3 = PW'(ptab[i]);
      apply(3, 1'b1, ptab[i] - 1, 1'b0);
      vectors++;
      if (ce3 !== etab[i]) begin
        miscompares++;
        $display("FAIL cfg_err_n3_p%0d: got %b expected %b", ptab[i], ce3, etab[i]);
      end
      apply(3, 1'b0, 0, 1'b0);
    end
    ps5 = PW'(16);
    apply(5, 1'b1, 0, 1'b0);
    vectors++;
    if (ce5 !== 1'b0) begin
      miscompares++;
      $display("FAIL cfg_err_n5_p16: got %b expected 0", ce5);
    end
  endtask

  task automatic test_samp_en_drop();
    test_window(3, 8, 3, 7'b0000111, 1'b1, 1'b0, "pre_drop");
    for (int e = 0; e < 5; e++) begin
      apply(3, 1'b1, e, 1'b1);
      vectors++;
      if (bv3 !== 1'b0) begin
        miscompares++;
        $display("FAIL drop_partial_valid edge %0d: got %b expected 0", e, bv3);
      end
    end
    apply(3, 1'b0, 5, 1'b1);
    vectors++;
    if ({sb3, bv3, ne3, ce3} !== 4'b0000) begin
      miscompares++;
      $display("FAIL drop_clears_outputs: got %b expected 0000", {sb3, bv3, ne3, ce3});
    end
    for (int e = 6; e < 8; e++) begin
      apply(3, 1'b1, e, 1'b1);
      vectors++;
      if (bv3 !== 1'b0) begin
        miscompares++;
        $display("FAIL drop_no_late_valid edge %0d: got %b expected 0", e, bv3);
      end
    end
    test_window(3, 8, 3, 7'b0000011, 1'b1, 1'b1, "post_drop");
  endtask

  task automatic test_skip();
    int seq[9] = '{0, 1, 2, 3, 5, 6, 7, 0, 1};
    ps3 = PW'(8);
    foreach (seq[i]) begin
      apply(3, 1'b1, seq[i], 1'b1);
      vectors++;
      if (bv3 !== 1'b0) begin
        miscompares++;
        $display("FAIL skip_abort step %0d edge %0d: got %b expected 0", i, seq[i], bv3);
      end
    end
    // Finish that period (edge 1 already applied) then a normal window.
    for (int e = 2; e < 8; e++) apply(3, 1'b1, e, 1'b0);
    test_window(3, 8, 3, 7'b0000111, 1'b1, 1'b0, "post_skip");
  endtask

  task automatic test_async_reset();
    test_window(3, 8, 3, 7'b0000111, 1'b1, 1'b0, "pre_reset");
    for (int e = 0; e < 5; e++) apply(3, 1'b1, e, 1'b1);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({sb3, bv3, ne3, ce3} !== 4'b0000) begin
      miscompares++;
      $display("FAIL async_reset_outputs: got %b expected 0000", {sb3, bv3, ne3, ce3});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int e = 5; e < 8; e++) begin
      apply(3, 1'b1, e, 1'b1);
      vectors++;
      if (bv3 !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_discards_partial edge %0d: got %b expected 0", e, bv3);
      end
    end
    test_window(3, 8, 3, 7'b0000110, 1'b1, 1'b1, "post_reset");
  endtask

  // Random prescales and line data over consecutive bit periods. Decisions
  // are predicted from the raw samples and queued; each bit_valid pops one.
  task automatic test_random(input int d, input int n);
    logic sb, bv, ne, ce, rx, pend, last_bit, last_noise;
    logic [1:0] got;
    int p, ws, we, ones;
    apply(d, 1'b0, 0, 1'b0);
    exp_q.delete();
    pend = 1'b0; last_bit = 1'b0; last_noise = 1'b0;
    for (int r = 0; r < 5; r++) begin
      p = $urandom_range(n + 1, 24);
      ws = p / 2 - (n - 1) / 2;
      we = ws + n - 1;
      if (d == 3) ps3 = PW'(p); else ps5 = PW'(p);
      for (int per = 0; per < 5; per++) begin
        ones = 0;
        for (int e = 0; e < p; e++) begin
          rx = 1'($urandom_range(0, 1));
          if (e >= ws && e <= we) ones += int'(rx);
          apply(d, 1'b1, e, rx);
          obs(d, sb, bv, ne, ce);
          vectors++;
          if ({bv, ce} !== {pend, 1'b0}) begin
            miscompares++;
            $display("FAIL rand_n%0d valid/cfg p=%0d edge %0d: got %b%b expected %b0", n, p, e, bv, ce, pend);
          end
          if (pend) begin
            got = exp_q.pop_front();
            last_bit = got[1]; last_noise = got[0];
          end
          vectors++;
          if ({sb, ne} !== {last_bit, last_noise}) begin
            miscompares++;
            $display("FAIL rand_n%0d bit/noise p=%0d edge %0d: got %b%b expected %b%b", n, p, e, sb, ne, last_bit, last_noise);
          end
          pend = (e == we);
          if (pend) exp_q.push_back({(2 * ones > n), (ones != 0 && ones != n)});
        end
      end
    end
    apply(d, 1'b1, 0, 1'b0);
    vectors++;
    if (bv5 === bv3 && 0) miscompares++;
    obs(d, sb, bv, ne, ce);
    if (bv !== pend) begin
      miscompares++;
      $display("FAIL rand_n%0d final valid: got %b expected %b", n, bv, pend);
    end
    if (pend) void'(exp_q.pop_front());
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rand_n%0d queue_drain: got %0d left expected 0", n, exp_q.size());
    end
    apply(d, 1'b0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_votes();
    test_cfg_err();
    test_samp_en_drop();
    test_skip();
    test_async_reset();
    test_random(3, 3);
    test_random(5, 5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/oversample_voter.md
OVERSAMPLE_VOTER -- requirements
Module: oversample_voter

Interface
REQ-001 Parameter PRESCALE_W, default 6: width of the prescale and edge_cnt buses.
REQ-002 Parameter NSAMP, default 3: samples per bit; legal values are the odd numbers 1, 3, 5 and 7.
REQ-003 Port clk, input, 1: rising-edge clock for all state.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port samp_en, input, 1: sampling enable; low forces the idle/cleared condition.
REQ-006 Port prescale, input, PRESCALE_W: oversampling ratio (edges per bit).
REQ-007 Port edge_cnt, input, PRESCALE_W: current edge index within the bit, 0..prescale-1.
REQ-008 Port rx_in, input, 1: serial line, already synchronised.
REQ-009 Port sampled_bit, output, 1: majority-voted bit value.
REQ-010 Port bit_valid, output, 1: one-cycle pulse when sampled_bit is updated.
REQ-011 Port noise_err, output, 1: non-unanimous samples in the last decision; qualified by bit_valid.
REQ-012 Port cfg_err, output, 1: prescale cannot hold the sample window.

Function
REQ-013 Definitions: MID = prescale>>1; H = (NSAMP-1)/2; window = edge_cnt values MID-H through MID+H.
REQ-014 cfg_err SHALL be registered as 1 when MID < H or MID+H >= prescale, and 0 otherwise, while samp_en=1.
REQ-015 While cfg_err=1, no samples SHALL be captured and bit_valid SHALL stay 0.
REQ-016 FSM states SHALL be IDLE, COLLECT and DECIDE, with a state register and a sample index k of width ceil(log2(NSAMP+1)).
REQ-017 IDLE transition: when samp_en=1, cfg_err condition false and edge_cnt == MID-H, capture rx_in, set k=1, ones=rx_in, and go to COLLECT (go straight to DECIDE if NSAMP=1).
REQ-018 COLLECT capture: when edge_cnt == MID-H+k, add rx_in to ones, increment k, and go to DECIDE when k reaches NSAMP.
REQ-019 COLLECT abort: edge_cnt == 0 (wrap) or edge_cnt > MID-H+k (skipped edge) SHALL discard the partial result and return to IDLE without bit_valid.
REQ-020 COLLECT hold: any other edge_cnt value SHALL keep the state unchanged.
REQ-021 DECIDE actions (one cycle): sampled_bit <= (ones > H); noise_err <= (ones != 0 && ones != NSAMP); bit_valid <= 1; go to IDLE.
REQ-022 Latency: bit_valid SHALL assert in the cycle after the clock edge that captured the last sample.
REQ-023 Between decisions, sampled_bit and noise_err SHALL hold their values; bit_valid SHALL be 0.
REQ-024 samp_en=0 in any state SHALL, at the next edge, force IDLE, k=0, ones=0, sampled_bit=0, noise_err=0, bit_valid=0 and cfg_err=0; this has priority over all other transitions.
REQ-025 ones SHALL be ceil(log2(NSAMP+1)) bits wide, and the vote SHALL be computed without overflow.
REQ-026 A new window start in IDLE SHALL be accepted in the cycle immediately after DECIDE.

Reset
REQ-027 rst=1 SHALL asynchronously set state=IDLE, k=0, ones=0, sampled_bit=0, bit_valid=0, noise_err=0 and cfg_err=0.
REQ-028 Reset asserted mid-COLLECT SHALL discard the partial sample set; after rst falls, no bit_valid SHALL occur until a full new window completes.

Verification
REQ-029 NSAMP=3, prescale=8, samp_en=1, rx_in=1 at edge_cnt 3,4,5 -> bit_valid pulses one cycle after the edge_cnt=5 capture; sampled_bit=1, noise_err=0.
REQ-030 NSAMP=3, prescale=8, rx_in=1,0,1 at edge_cnt 3,4,5 -> sampled_bit=1, noise_err=1; rx_in=0,0,1 -> sampled_bit=0, noise_err=1.
REQ-031 NSAMP=5, prescale=16, rx_in=0,1,1,0,1 at edge_cnt 6..10 -> sampled_bit=1, noise_err=1; NSAMP=5, prescale=4 -> cfg_err=1 and bit_valid never asserts.
REQ-032 NSAMP=3, prescale=8, samp_en dropped after edge_cnt=4 -> no bit_valid; sampled_bit=0 next cycle; the next full window decides normally.
REQ-033 NSAMP=3, prescale=8, edge_cnt sequence 3,5 (4 skipped) -> abort and no bit_valid; rst pulsed mid-window asynchronously -> all outputs 0 before the next clock edge.
